// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads take absolute priority,
// then buffered host writes, then a single outstanding host read.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          scan_req,
    input  logic [ADDR_W-1:0]             scan_addr,
    output logic                          scan_valid,
    output logic [DATA_W-1:0]             scan_data,
    input  logic                          host_wr_valid,
    output logic                          host_wr_ready,
    input  logic [ADDR_W-1:0]             host_wr_addr,
    input  logic [DATA_W-1:0]             host_wr_data,
    input  logic                          host_rd_req,
    input  logic [ADDR_W-1:0]             host_rd_addr,
    output logic                          host_rd_busy,
    output logic                          host_rd_valid,
    output logic [DATA_W-1:0]             host_rd_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout,
    output logic                          ram_ce,
    output logic                          ram_wren,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ISSUED, RD_RETURN} rd_state_t;
    typedef enum logic [1:0] {OP_NONE, OP_SCAN, OP_HOST, OP_WR} op_t;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_wr_ready;

    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_busy;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_hold;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_ram_ce;
    logic              r_ram_wren;
    op_t               r_pin_op;
    logic              r_scan_valid;
    logic              r_ret_host;

    op_t               w_gnt;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level_nxt;

    assign w_push      = host_wr_valid & r_wr_ready;
    assign w_empty     = (r_level == '0);
    assign w_pop       = (w_gnt == OP_WR);
    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // Grant: scanout, then queued writes, then the host read once writes have drained
    always_comb begin
        w_gnt      = OP_NONE;
        w_gnt_addr = r_ram_addr;
        if (scan_req) begin
            w_gnt      = OP_SCAN;
            w_gnt_addr = scan_addr;
        end else if (!w_empty) begin
            w_gnt      = OP_WR;
            w_gnt_addr = r_fifo_addr[r_rd_ptr];
        end else if (r_rd_state == RD_WAIT) begin
            w_gnt      = OP_HOST;
            w_gnt_addr = r_rd_addr;
        end
    end

    // FIFO storage carries no reset; only pointers and level define contents
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= host_wr_addr;
            r_fifo_data[r_wr_ptr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level    <= w_level_nxt;
            r_wr_ready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE:   if (host_rd_req) w_rd_state_nxt = RD_WAIT;
            RD_WAIT:   if (w_gnt == OP_HOST) w_rd_state_nxt = RD_ISSUED;
            RD_ISSUED: w_rd_state_nxt = RD_RETURN;
            RD_RETURN: w_rd_state_nxt = RD_IDLE;
            default:   w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_state <= RD_IDLE;
            r_rd_addr  <= '0;
            r_rd_busy  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (r_rd_state == RD_IDLE && host_rd_req) r_rd_addr <= host_rd_addr;
            r_rd_busy  <= (w_rd_state_nxt == RD_WAIT) || (w_rd_state_nxt == RD_ISSUED);
            r_rd_valid <= (w_rd_state_nxt == RD_RETURN);
        end
    end

    // RAM pins one cycle after grant; return tag one cycle after the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_ce     <= 1'b0;
            r_ram_wren   <= 1'b0;
            r_pin_op     <= OP_NONE;
            r_scan_valid <= 1'b0;
            r_ret_host   <= 1'b0;
            r_rd_hold    <= '0;
        end else begin
            r_ram_addr   <= w_gnt_addr;
            r_ram_ce     <= (w_gnt != OP_NONE);
            r_ram_wren   <= (w_gnt == OP_WR);
            if (w_gnt == OP_WR) r_ram_din <= r_fifo_data[r_rd_ptr];
            r_pin_op     <= w_gnt;
            r_scan_valid <= (r_pin_op == OP_SCAN);
            r_ret_host   <= (r_pin_op == OP_HOST);
            if (r_ret_host) r_rd_hold <= ram_dout;
        end
    end

    assign scan_valid    = r_scan_valid;
    assign scan_data     = r_scan_valid ? ram_dout : '0;
    assign host_rd_valid = r_rd_valid;
    assign host_rd_data  = r_ret_host ? ram_dout : r_rd_hold;
    assign host_rd_busy  = r_rd_busy;
    assign host_wr_ready = r_wr_ready;
    assign fifo_level    = r_level;
    assign ram_addr      = r_ram_addr;
    assign ram_din       = r_ram_din;
    assign ram_ce        = r_ram_ce;
    assign ram_wren      = r_ram_wren;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM model, queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fb_port_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int K_NONE = 0, K_SCAN = 1, K_WR = 2, K_HRD = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          scan_req, host_wr_valid, host_rd_req;
    logic [AW-1:0] scan_addr, host_wr_addr, host_rd_addr;
    logic [DW-1:0] host_wr_data;
    logic          scan_valid, host_wr_ready, host_rd_busy, host_rd_valid;
    logic [DW-1:0] scan_data, host_rd_data, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_ce, ram_wren;
    logic [LW-1:0] fifo_level;

    int n_vec  = 0;
    int n_fail = 0;

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_busy(host_rd_busy), .host_rd_valid(host_rd_valid),
        .host_rd_data(host_rd_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ce(ram_ce), .ram_wren(ram_wren), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, 1-cycle read latency, preloaded with data = addr
    logic [DW-1:0] mem [1<<AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        ram_dout = '0;
        forever begin
            @(posedge clk);
            if (ram_ce) begin
                if (ram_wren) mem[ram_addr] <= ram_din;
                else          ram_dout      <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what each output must show in the cycle after every edge
    logic [AW+DW-1:0] mq[$];
    logic [DW-1:0]    shadow [1<<AW];
    int               pin_kind, g;
    logic             rd_wait_m, idle_m;
    logic [AW-1:0]    rd_addr_m;
    logic [DW-1:0]    rd_hold, rdata;
    logic [AW+DW-1:0] ent;
    logic             e_ce, e_wren, e_sv, e_rv, e_busy, e_ready;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_din, e_sd, e_rd;
    logic [LW-1:0]    e_level;

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(i);
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                pin_kind = K_NONE; rd_wait_m = 1'b0; rd_addr_m = '0; rd_hold = '0;
                e_ce = 1'b0; e_wren = 1'b0; e_sv = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
                e_ready = 1'b0; e_addr = '0; e_din = '0; e_sd = '0; e_rd = '0; e_level = '0;
            end else begin
                rdata = '0;
                if (pin_kind == K_WR) shadow[e_addr] = e_din;
                else if (pin_kind != K_NONE) rdata = shadow[e_addr];
                e_sv = (pin_kind == K_SCAN);
                e_sd = e_sv ? rdata : '0;
                idle_m = !rd_wait_m && pin_kind != K_HRD && !e_rv;
                e_rv = (pin_kind == K_HRD);
                if (e_rv) rd_hold = rdata;
                e_rd = rd_hold;
                if (scan_req)             g = K_SCAN;
                else if (mq.size() != 0)  g = K_WR;
                else if (rd_wait_m)       g = K_HRD;
                else                      g = K_NONE;
                if (g == K_SCAN) e_addr = scan_addr;
                if (g == K_HRD) begin e_addr = rd_addr_m; rd_wait_m = 1'b0; end
                if (g == K_WR) begin
                    ent = mq.pop_front();
                    e_addr = ent[AW+DW-1:DW];
                    e_din  = ent[DW-1:0];
                end
                pin_kind = g;
                e_ce   = (g != K_NONE);
                e_wren = (g == K_WR);
                if (host_wr_valid && e_ready) mq.push_back({host_wr_addr, host_wr_data});
                if (host_rd_req && idle_m) begin rd_wait_m = 1'b1; rd_addr_m = host_rd_addr; end
                e_busy  = rd_wait_m || (pin_kind == K_HRD);
                e_level = LW'(mq.size());
                e_ready = (mq.size() != DEPTH);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ram_ce", 32'(ram_ce), 32'(e_ce));
            chk("ram_wren", 32'(ram_wren), 32'(e_wren));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_din", 32'(ram_din), 32'(e_din));
            chk("scan_valid", 32'(scan_valid), 32'(e_sv));
            chk("scan_data", 32'(scan_data), 32'(e_sd));
            chk("host_rd_valid", 32'(host_rd_valid), 32'(e_rv));
            chk("host_rd_data", 32'(host_rd_data), 32'(e_rd));
            chk("host_rd_busy", 32'(host_rd_busy), 32'(e_busy));
            chk("host_wr_ready", 32'(host_wr_ready), 32'(e_ready));
            chk("fifo_level", 32'(fifo_level), 32'(e_level));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        scan_req = 1'b0; host_wr_valid = 1'b0; host_rd_req = 1'b0;
    endtask

    task automatic wait_rd_valid(input string nm, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (host_rd_valid) ok = 1'b1;
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic ok;
    int   pct;

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        scan_addr = '0; host_wr_addr = '0; host_wr_data = '0; host_rd_addr = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(host_wr_ready), 32'd0);
        chk("rst_ce", 32'(ram_ce), 32'd0);

        // Two back-to-back writes with no scanout
        tick();
        host_wr_valid = 1'b1; host_wr_addr = AW'(32'h10); host_wr_data = 8'hA5;
        @(negedge clk);
        chk("w1_ready", 32'(host_wr_ready), 32'd1);
        tick();
        host_wr_addr = AW'(32'h11); host_wr_data = 8'h5A;
        @(negedge clk);
        chk("w1_level1", 32'(fifo_level), 32'd1);
        tick();
        host_wr_valid = 1'b0;
        @(negedge clk);
        chk("w1_wren_a", 32'(ram_wren), 32'd1);
        chk("w1_addr_a", 32'(ram_addr), 32'h10);
        chk("w1_din_a", 32'(ram_din), 32'hA5);
        tick();
        @(negedge clk);
        chk("w1_addr_b", 32'(ram_addr), 32'h11);
        chk("w1_din_b", 32'(ram_din), 32'h5A);
        chk("w1_level0", 32'(fifo_level), 32'd0);
        tick();
        @(negedge clk);
        chk("w1_ce_off", 32'(ram_ce), 32'd0);

        // Eight-pixel scan burst
        for (int i = 0; i < 11; i++) begin
            tick();
            scan_req = (i < 8); scan_addr = AW'(i);
            @(negedge clk);
            if (i >= 2 && i < 10) begin
                chk("burst_valid", 32'(scan_valid), 32'd1);
                chk("burst_data", 32'(scan_data), 32'(i - 2));
            end
            if (i == 10) chk("burst_end", 32'(scan_valid), 32'd0);
        end

        // FIFO overflow under continuous scanout, then drain
        for (int i = 0; i < 5; i++) begin
            tick();
            scan_req = 1'b1; scan_addr = AW'(i);
            host_wr_valid = 1'b1; host_wr_addr = AW'(32'h200 + i); host_wr_data = DW'(8'hC0 + i);
            @(negedge clk);
            if (i == 4) begin
                chk("ovf_ready", 32'(host_wr_ready), 32'd0);
                chk("ovf_level", 32'(fifo_level), 32'd4);
            end
        end
        tick();
        host_wr_valid = 1'b0;
        @(negedge clk);
        chk("ovf_level_hold", 32'(fifo_level), 32'd4);
        tick();
        scan_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("drain_wren", 32'(ram_wren), 32'd1);
            chk("drain_addr", 32'(ram_addr), 32'h200 + 32'(k));
            chk("drain_din", 32'(ram_din), 32'hC0 + 32'(k));
        end

        // Read-after-write to the same address
        tick();
        host_wr_valid = 1'b1; host_wr_addr = AW'(32'h100); host_wr_data = 8'h33;
        tick();
        host_wr_valid = 1'b0; host_rd_req = 1'b1; host_rd_addr = AW'(32'h100);
        tick();
        host_rd_req = 1'b0;
        @(negedge clk);
        chk("raw_busy", 32'(host_rd_busy), 32'd1);
        wait_rd_valid("raw", ok);
        if (ok) begin
            chk("raw_data", 32'(host_rd_data), 32'h33);
            chk("raw_busy_clr", 32'(host_rd_busy), 32'd0);
        end

        // Scan, write and read all contending
        repeat (4) tick();
        scan_req = 1'b1; scan_addr = AW'(32'h20);
        host_wr_valid = 1'b1; host_wr_addr = AW'(32'h21); host_wr_data = 8'h77;
        host_rd_req = 1'b1; host_rd_addr = AW'(32'h21);
        tick();
        scan_addr = AW'(32'h22); host_wr_valid = 1'b0; host_rd_req = 1'b0;
        tick();
        scan_req = 1'b0;
        wait_rd_valid("mix", ok);
        if (ok) chk("mix_data", 32'(host_rd_data), 32'h77);

        // Reset during the read-return cycle with two writes queued
        repeat (4) tick();
        host_rd_req = 1'b1; host_rd_addr = AW'(32'h30);
        tick();
        host_rd_req = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = AW'(32'h40); host_wr_data = 8'h11;
        tick();
        scan_req = 1'b1; scan_addr = AW'(32'h5);
        host_wr_addr = AW'(32'h41); host_wr_data = 8'h22;
        @(posedge clk);
        #1;
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        chk("pre_rst_rvalid", 32'(host_rd_valid), 32'd1);
        #1;
        idle_inputs();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(host_rd_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(host_rd_busy), 32'd0);
        chk("mid_rst_ce", 32'(ram_ce), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Random traffic on a small address window to exercise hazards
        pct = 30;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 64 == 0) pct = (($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 30 : 90));
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
            scan_req      = ($urandom_range(0, 99) < pct);
            scan_addr     = AW'($urandom_range(0, 31));
            host_wr_valid = ($urandom_range(0, 2) == 0);
            host_wr_addr  = AW'($urandom_range(0, 31));
            host_wr_data  = DW'($urandom);
            host_rd_req   = ($urandom_range(0, 3) == 0);
            host_rd_addr  = AW'($urandom_range(0, 31));
        end
        reset_n = 1'b1;
        idle_inputs();
        repeat (12) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
